core_io_ctrl: RTL and testbench
===============================

// Module: core_io_ctrl
// PURPOSE
// - Controller between riscv_pipeline's I/O port (out_issued/out_data/out_stall, in_issued/in_data/in_stall)
//   and the byte-wide UART TX/RX modules. Buffers output bytes and input bytes in two FIFOs.
// - Generates the core stall signals so out/in instructions block until data or space exists.
// PARAMETERS
// - TX_DEPTH  16  TX FIFO depth in bytes (power of two, >=4)
// - RX_DEPTH  16  RX FIFO depth in bytes (power of two, >=4)
// PORTS
// - clk          in   1   clock; all logic on posedge
// - rst          in   1   asynchronous, active-high reset
// - out_issued   in   1   core executes an output instruction this cycle
// - out_data     in   32  core output value; bits [7:0] are the byte sent
// - out_stall    out  1   TX FIFO full; core must hold the out instruction
// - in_issued    in   1   core executes an input instruction this cycle
// - in_data      out  32  input value returned to core
// - in_stall     out  1   not enough RX bytes; core must hold the in instruction
// - tx_data      out  8   byte to UART TX
// - tx_valid     out  1   tx_data valid
// - tx_ready     in   1   UART TX accepts byte when tx_valid & tx_ready
// - rx_data      in   8   byte from UART RX
// - rx_valid     in   1   one-cycle pulse, rx_data valid; no backpressure
// - rx_overflow  out  1   sticky: RX byte dropped because RX FIFO full
// - tx_count     out  32  total bytes handed to UART TX (wraps at 2^32)
// BEHAVIOUR
// - Reset (async, any cycle, mid-transfer included): both FIFOs emptied; out_stall=1 is NOT used at reset:
//   out_stall=0, in_stall=1, tx_valid=0, tx_data=0, in_data=0, rx_overflow=0, tx_count=0.
// - TX push: out_issued & ~out_stall -> out_data[7:0] written to TX FIFO; visible on tx_data next cycle.
// - out_stall = TX FIFO full (registered count, no combinational path from tx_ready).
// - out_issued while out_stall=1: ignored, nothing written (core guarantees it retries).
// - TX pop: tx_valid = TX FIFO not empty; tx_data = head byte; tx_valid & tx_ready pops, tx_count += 1.
// - TX simultaneous push+pop when full: push refused (stall already high), pop proceeds; count -1.
// - RX push: rx_valid & RX FIFO not full -> rx_data written. rx_valid & full & no pop this cycle -> byte
//   dropped, rx_overflow set until reset. rx_valid & full & pop same cycle -> byte accepted, count unchanged.
// - in_stall = RX count < N (N=4 with CORE_IO_WORD_IN_EN, else N=1); from registered count.
// - in_issued & ~in_stall: in_data valid combinationally that cycle from FIFO head; N bytes popped.
//   in_issued while in_stall=1: no pop; in_data=0.
// - FIFO pointers log2(DEPTH)+1 bits; wrap naturally; full = MSBs differ & low bits equal.
// - Latency: out byte to tx_valid = 1 cycle; rx byte to in_stall drop = 1 cycle after the Nth byte.
// CONFIGURATION
// - CORE_IO_WORD_IN_EN defined: in_data = {b3,b2,b1,b0}, little-endian, b0 = oldest byte; pops 4 bytes;
//   RX FIFO exposes its 4 oldest entries.
// - Undefined: in_data = {24'b0, b0}; pops 1 byte. TX path unaffected either way.
// STRUCTURE
// - core_io_pkg: IO_BYTE_W=8, IO_WORD_W=32, IO_WORD_BYTES=4, ptr-width function clog2.
// - Sub-module io_byte_fifo (DEPTH, pop count 1..4, peek of 4 oldest entries, count output);
//   instantiated twice (TX with pop=1, RX with pop=N). Top holds stall, overflow, tx_count logic.
// TESTING
// - Reset then 3 out_issued bytes 0x41,0x42,0x43 with tx_ready=1 -> tx_data 41,42,43 in order, tx_count=3.
// - tx_ready=0, issue 17 bytes with TX_DEPTH=16 -> out_stall=1 after 16th; 17th not written; release
//   tx_ready -> all 16 drain, out_stall falls the cycle after first pop.
// - Word mode: rx bytes 0x78,0x56,0x34,0x12, then in_issued -> in_data=0x12345678, in_stall high before
//   4th byte registered; byte mode same stimulus -> four reads 0x78,0x56,0x34,0x12.
// - Fill RX (16 bytes), send 0xAA with no pop -> rx_overflow=1, FIFO contents unchanged; send 0xBB same
//   cycle as a pop -> accepted, rx_overflow stays 1.
// - Assert rst mid-drain with 5 TX bytes queued -> tx_valid=0 immediately, tx_count=0, in_stall=1.

Source files
------------

// File: rtl/core_io_pkg.sv
// core_io_pkg: shared widths and pointer-width helper for core_io_ctrl
package core_io_pkg;
  localparam int IO_BYTE_W = 8;
  localparam int IO_WORD_W = 32;
  localparam int IO_WORD_BYTES = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/io_byte_fifo.sv
// io_byte_fifo: byte FIFO (clk, rst, push/din, pop of POP_N bytes, count, full, peek of PEEK_N oldest bytes)
module io_byte_fifo
  import core_io_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int POP_N  = 1,
  parameter int PEEK_N = IO_WORD_BYTES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [IO_BYTE_W-1:0]        din,
  input  logic                        pop,
  output logic [clog2(DEPTH):0]       count,
  output logic                        full,
  output logic [IO_BYTE_W*PEEK_N-1:0] peek
);
  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [IO_BYTE_W-1:0] mem_q [DEPTH];
  always_comb begin
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + (pop ? PW'(POP_N) : '0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  assign count = wr_q - rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  for (genvar i = 0; i < PEEK_N; i++) begin : g_peek
    assign peek[IO_BYTE_W*i +: IO_BYTE_W] = mem_q[rd_q[AW-1:0] + AW'(i)];
  end
endmodule

// File: rtl/core_io_ctrl.sv
// core_io_ctrl: core out/in port to UART byte TX/RX bridge via two FIFOs with stalls, sticky rx_overflow, tx_count; CORE_IO_WORD_IN_EN makes in reads 4-byte little-endian words
module core_io_ctrl
  import core_io_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 out_issued,
  input  logic [IO_WORD_W-1:0] out_data,
  output logic                 out_stall,
  input  logic                 in_issued,
  output logic [IO_WORD_W-1:0] in_data,
  output logic                 in_stall,
  output logic [IO_BYTE_W-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [IO_BYTE_W-1:0] rx_data,
  input  logic                 rx_valid,
  output logic                 rx_overflow,
  output logic [IO_WORD_W-1:0] tx_count
);
`ifdef CORE_IO_WORD_IN_EN
  localparam int N = IO_WORD_BYTES;
`else
  localparam int N = 1;
`endif
  localparam int TW = clog2(TX_DEPTH);
  localparam int RW = clog2(RX_DEPTH);
  logic tx_full, rx_full, tx_push, tx_pop, rx_push, in_pop, rx_overflow_d, rx_overflow_q;
  logic [TW:0] tx_cnt;
  logic [RW:0] rx_cnt;
  logic [IO_BYTE_W-1:0] tx_head;
  logic [IO_BYTE_W*N-1:0] rx_peek;
  logic [IO_WORD_W-1:0] tx_count_d, tx_count_q;
  io_byte_fifo #(.DEPTH(TX_DEPTH), .POP_N(1), .PEEK_N(1)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .din(out_data[IO_BYTE_W-1:0]), .pop(tx_pop),
    .count(tx_cnt), .full(tx_full), .peek(tx_head)
  );
  io_byte_fifo #(.DEPTH(RX_DEPTH), .POP_N(N), .PEEK_N(N)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .din(rx_data), .pop(in_pop),
    .count(rx_cnt), .full(rx_full), .peek(rx_peek)
  );
  always_comb begin
    out_stall = tx_full;
    tx_push = out_issued && !tx_full;
    tx_valid = tx_cnt != '0;
    tx_pop = tx_valid && tx_ready;
    tx_data = tx_valid ? tx_head : '0;
    in_stall = rx_cnt < (RW+1)'(N);
    in_pop = in_issued && !in_stall;
    in_data = in_pop ? IO_WORD_W'(rx_peek) : '0;
    rx_push = rx_valid && (!rx_full || in_pop);
    rx_overflow_d = rx_overflow_q || (rx_valid && rx_full && !in_pop);
    tx_count_d = tx_count_q + IO_WORD_W'(tx_pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_overflow_q <= 1'b0;
      tx_count_q <= '0;
    end else begin
      rx_overflow_q <= rx_overflow_d;
      tx_count_q <= tx_count_d;
    end
  assign rx_overflow = rx_overflow_q;
  assign tx_count = tx_count_q;
endmodule

// File: tb/tb_core_io_ctrl.sv
// tb_core_io_ctrl: vector table plus queue scoreboard bench for core_io_ctrl
module tb_core_io_ctrl;
`ifdef CORE_IO_WORD_IN_EN
  localparam int N = 4;
`else
  localparam int N = 1;
`endif
  localparam int TXD = 16;
  localparam int RXD = 16;
  logic clk = 0, rst = 1;
  logic out_issued = 0, in_issued = 0, tx_ready = 0, rx_valid = 0;
  logic [31:0] out_data = 0;
  logic [7:0] rx_data = 0;
  logic out_stall, in_stall, tx_valid, rx_overflow;
  logic [31:0] in_data, tx_count;
  logic [7:0] tx_data;
  int total = 0, pass = 0;
  logic [7:0] txq[$], rxq[$];
  logic m_ovf = 0;
  logic [31:0] m_cnt = 0;
  typedef struct {
    logic oi;
    logic [7:0] od;
    logic tr;
    logic e_tv;
    logic [7:0] e_td;
    logic [31:0] e_cnt;
  } vec_t;
  vec_t vt[5];
  logic [7:0] rbytes[4];
  core_io_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst), .out_issued(out_issued), .out_data(out_data), .out_stall(out_stall),
    .in_issued(in_issued), .in_data(in_data), .in_stall(in_stall), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_overflow(rx_overflow), .tx_count(tx_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_out_stall"}, 32'(out_stall), 0);
    chk({tag, "_in_stall"}, 32'(in_stall), 1);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
    chk({tag, "_tx_data"}, 32'(tx_data), 0);
    chk({tag, "_in_data"}, in_data, 0);
    chk({tag, "_rx_overflow"}, 32'(rx_overflow), 0);
    chk({tag, "_tx_count"}, tx_count, 0);
  endtask
  task automatic step(input logic oi, input logic [7:0] od, input logic tr,
                      input logic rv, input logic [7:0] rd, input logic ii);
    logic e_ost, e_tv, e_ist, ipop, acc;
    logic [7:0] e_td;
    logic [31:0] e_id;
    @(negedge clk);
    out_issued = oi;
    out_data = {24'($urandom), od};
    tx_ready = tr;
    rx_valid = rv;
    rx_data = rd;
    in_issued = ii;
    #1;
    e_ost = txq.size() == TXD;
    e_tv = txq.size() != 0;
    e_td = e_tv ? txq[0] : 8'h00;
    e_ist = rxq.size() < N;
    ipop = ii && !e_ist;
    e_id = 0;
    if (ipop) for (int k = 0; k < N; k++) e_id[8*k +: 8] = rxq[k];
    chk("out_stall", 32'(out_stall), 32'(e_ost));
    chk("tx_valid", 32'(tx_valid), 32'(e_tv));
    chk("tx_data", 32'(tx_data), 32'(e_td));
    chk("in_stall", 32'(in_stall), 32'(e_ist));
    chk("in_data", in_data, e_id);
    chk("rx_overflow", 32'(rx_overflow), 32'(m_ovf));
    chk("tx_count", tx_count, m_cnt);
    if (oi && !e_ost) txq.push_back(od);
    if (e_tv && tr) begin
      void'(txq.pop_front());
      m_cnt++;
    end
    acc = rv && (rxq.size() < RXD || ipop);
    if (rv && rxq.size() == RXD && !ipop) m_ovf = 1;
    if (ipop) repeat (N) void'(rxq.pop_front());
    if (acc) rxq.push_back(rd);
  endtask
  initial begin
    vt[0] = '{1'b1, 8'h41, 1'b1, 1'b0, 8'h00, 32'd0};
    vt[1] = '{1'b1, 8'h42, 1'b1, 1'b1, 8'h41, 32'd0};
    vt[2] = '{1'b1, 8'h43, 1'b1, 1'b1, 8'h42, 32'd1};
    vt[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h43, 32'd2};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'd3};
    rbytes = '{8'h78, 8'h56, 8'h34, 8'h12};
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      step(vt[i].oi, vt[i].od, vt[i].tr, 0, 0, 0);
      chk("tbl_tx_valid", 32'(tx_valid), 32'(vt[i].e_tv));
      chk("tbl_tx_data", 32'(tx_data), 32'(vt[i].e_td));
      chk("tbl_tx_count", tx_count, vt[i].e_cnt);
    end
    for (int i = 0; i < 17; i++) step(1, 8'(8'h80 + i), 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("tx_full_stall", 32'(out_stall), 1);
    chk("tx_full_head", 32'(tx_data), 32'h80);
    step(1, 8'hEE, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("stall_drop", 32'(out_stall), 0);
    for (int g = 0; g < 40 && txq.size() != 0; g++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("tx_count_total", tx_count, 19);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, rbytes[i], 0);
`ifdef CORE_IO_WORD_IN_EN
    step(0, 0, 0, 0, 0, 1);
    chk("word_read", in_data, 32'h12345678);
`else
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1);
      chk("byte_read", in_data, {24'h0, rbytes[i]});
    end
`endif
    step(0, 0, 0, 0, 0, 0);
    chk("rx_empty_stall", 32'(in_stall), 1);
    for (int i = 0; i < RXD; i++) step(0, 0, 0, 1, 8'(8'h10 + i), 0);
    step(0, 0, 0, 1, 8'hAA, 0);
    step(0, 0, 0, 1, 8'hBB, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("ovf_sticky", 32'(rx_overflow), 1);
    for (int g = 0; g < 40 && rxq.size() >= N; g++) step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 8'h99, 0);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    tx_ready = 1;
    #2 rst = 1;
    #1;
    chk_reset("mid_reset");
    txq.delete();
    rxq.delete();
    m_ovf = 0;
    m_cnt = 0;
    @(negedge clk);
    rst = 0;
    tx_ready = 0;
    step(1, 8'h5A, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("post_reset_data", 32'(tx_data), 32'h5A);
    step(0, 0, 0, 0, 0, 0);
    chk("post_reset_count", tx_count, 1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
